sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock synchronous FIFO that buffers a data word stream between a producer and a consumer in the same clock domain. It provides registered read data, occupancy flags (full, almost-full, empty, almost-empty), a write acknowledge and sticky-free per-cycle overflow/underflow error strobes. Testbenches reach it through a bundled interface, and a scoreboard monitor checks it against a reference model.

## Interface
- FIFO_WIDTH, 16: data word width in bits.
- FIFO_DEPTH, 8: number of storage entries; must be a power of two and at least 4.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; synchronous and active-high.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  registered read data.
- wr_ack  output  1  registered; the write request in the previous cycle was accepted.
- overflow  output  1  registered; the write request in the previous cycle was rejected because the FIFO was full.
- underflow  output  1  registered; the read request in the previous cycle was rejected because the FIFO was empty.
- full  output  1  combinational; count == FIFO_DEPTH.
- almostfull  output  1  combinational; count == FIFO_DEPTH-1.
- empty  output  1  combinational; count == 0.
- almostempty  output  1  combinational; count == 1.

## Operation
- State:
  - storage array mem[FIFO_DEPTH];
  - wr_ptr and rd_ptr, each log2(FIFO_DEPTH) bits, wrapping naturally modulo FIFO_DEPTH;
  - count, log2(FIFO_DEPTH)+1 bits.
- Write accept, when wr_en && !full:
  - mem[wr_ptr] <= data_in;
  - wr_ptr increments;
  - wr_ack <= 1.
- Write otherwise:
  - wr_ack <= 0;
  - overflow <= (wr_en && full).
- Read accept, when rd_en && !empty:
  - data_out <= mem[rd_ptr];
  - rd_ptr increments.
- Read otherwise:
  - data_out holds its value;
  - underflow <= (rd_en && empty).
- Flags are evaluated on the pre-edge count. Accept decisions therefore use the flags as they stand during the request cycle.
- Count update:
  - write only: +1.
  - read only: -1.
  - both accepted: unchanged.
  - both requested while empty: only the write is accepted, so +1, and underflow is 1.
  - both requested while full: only the read is accepted, so -1, and overflow is 1.
- Data order is strict FIFO. Pointer wrap-around is transparent.
- Reset (rst=1 at a clock edge) clears:
  - wr_ptr, rd_ptr and count to 0;
  - data_out to 0;
  - wr_ack, overflow and underflow to 0.
- Reset does not clear mem contents.
- Reset overrides any simultaneous wr_en or rd_en.
- Reset asserted mid-stream discards all stored words. After reset, empty=1 and full=0.

## Timing
- Write latency: a word written at edge N is readable by an rd_en sampled at edge N+1. data_out shows the word after edge N+1.
- Read latency: 1 cycle. data_out is valid after the edge that samples an accepted rd_en.
- wr_ack, overflow and underflow are single-cycle pulses, valid after the edge that samples the request.
- Full/empty/almost flags change combinationally with count after each edge.
- Sustained throughput: one write and one read per cycle.

## Structure
- Shared package fifo_pkg contains:
  - FIFO_WIDTH and FIFO_DEPTH defaults;
  - a derived localparam for pointer width;
  - the transaction class or typedef used by the monitor and scoreboard.
- Signals are bundled in interface FIFO_INT(clk), with modports for DUT, testbench and monitor.
- The block is a single module with no sub-module. The storage array, pointer logic and counter are inline.

## Test plan
- Reset: assert rst for 2 cycles mid-stream, then check:
  - empty=1, full=0, almostempty=0;
  - data_out=0, wr_ack=0, overflow=0, underflow=0;
  - a subsequent read gives underflow=1.
- Fill and drain: write 0x0001..0x0008, then read 8 times.
  - During the fill: almostfull=1 after the 7th write, full=1 after the 8th, and wr_ack=1 on each write.
  - During the drain: data_out returns 0x0001..0x0008 in order, almostempty=1 at count 1, and empty=1 after the last read.
- Overflow: with the FIFO full, write 0xBEEF.
  - Required: overflow=1, wr_ack=0, count stays 8.
  - Draining returns the original 8 words without 0xBEEF.
- Underflow: with the FIFO empty, issue rd_en.
  - Required: underflow=1, data_out unchanged.
- Simultaneous requests at the boundaries:
  - Empty, wr_en=rd_en=1 with data_in=0x1234: count=1, underflow=1, and the next read returns 0x1234.
  - Full, wr_en=rd_en=1: count=7, overflow=1, and the oldest word appears on data_out.
- Wrap-around: keep count at 4 while running 20 cycles of simultaneous read+write with incrementing data.
  - count stays 4 throughout.
  - Output order matches the scoreboard queue model with no gaps.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO defaults, derived widths and the monitor transaction type.
// Imported by the FIFO RTL, its bundled interface and testbenches.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_PTR_W = $clog2(DEF_DEPTH);

  typedef struct packed {
    logic                 wr_en;
    logic                 rd_en;
    logic [DEF_WIDTH-1:0] data_in;
    logic [DEF_WIDTH-1:0] data_out;
    logic                 wr_ack;
    logic                 overflow;
    logic                 underflow;
    logic                 full;
    logic                 empty;
  } fifo_txn_t;

endpackage

// File: rtl/fifo_if.sv
// FIFO_INT: bundles the sync_fifo ports for benches and monitors.
// Ports: clk in; all FIFO signals as members, grouped by modport.
interface FIFO_INT
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH
) (
  input logic clk
);

  logic                  rst;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;

  modport DUT (
    input  clk, rst, data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow,
    output underflow, full, almostfull,
    output empty, almostempty
  );

  modport TB (
    input  clk, data_out, wr_ack, overflow,
    input  underflow, full, almostfull,
    input  empty, almostempty,
    output rst, data_in, wr_en, rd_en
  );

  modport MON (
    input clk, rst, data_in, wr_en, rd_en,
    input data_out, wr_ack, overflow,
    input underflow, full, almostfull,
    input empty, almostempty
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered read data, ack/error strobes.
// Ports: clk, rst (sync high), data_in/wr_en/rd_en in; data_out,
// wr_ack, overflow, underflow, full, almostfull, empty, almostempty out.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL =
    (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_AFULL =
    (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0] CNT_ONE =
    (AW+1)'(1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_go;
  logic rd_go;

  // Flags come straight from the pre-edge count, so the
  // accept decisions below see the same view as the ports.
  assign full        = (count_q == CNT_FULL);
  assign almostfull  = (count_q == CNT_AFULL);
  assign empty       = (count_q == '0);
  assign almostempty = (count_q == CNT_ONE);

  assign wr_go = wr_en & ~full;
  assign rd_go = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = wr_go;
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;

    if (wr_go) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_go) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_go, rd_go})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; the cleared pointers make
  // stale words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && wr_go) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue model plus read-data scoreboard.
// Ports: none; drives and samples the DUT directly.
module tb_sync_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_out;
  logic         wr_ack;
  logic         overflow;
  logic         underflow;
  logic         full;
  logic         almostfull;
  logic         empty;
  logic         almostempty;

  int checks = 0;
  int fails  = 0;

  logic [W-1:0] mq [$];
  logic [W-1:0] sb_q [$];
  logic [W-1:0] m_dout = '0;

  always #5 clk = ~clk;

  sync_fifo #(
    .FIFO_WIDTH(W),
    .FIFO_DEPTH(D)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .wr_ack     (wr_ack),
    .overflow   (overflow),
    .underflow  (underflow),
    .full       (full),
    .almostfull (almostfull),
    .empty      (empty),
    .almostempty(almostempty)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_flags(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".full"},  32'(full),  32'(n == D));
    chk({tag, ".afull"}, 32'(almostfull), 32'(n == D-1));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".aempty"}, 32'(almostempty), 32'(n == 1));
  endtask

  task automatic step(
    input bit           w,
    input bit           r,
    input logic [W-1:0] d
  );
    bit wa, ra, mfull, mempty;
    mfull  = (mq.size() == D);
    mempty = (mq.size() == 0);
    wa = w && !mfull;
    ra = r && !mempty;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    if (ra) sb_q.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wr_ack", 32'(wr_ack), 32'(wa));
    chk("overflow", 32'(overflow), 32'(w && mfull));
    chk("underflow", 32'(underflow), 32'(r && mempty));
    if (ra) begin
      if (sb_q.size() == 0) chk("sb_empty", 32'(1), 32'(0));
      else m_dout = sb_q.pop_front();
    end
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk_flags("step");
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    data_in = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    mq.delete();
    sb_q.delete();
    m_dout = '0;
    chk("rst.empty", 32'(empty), 32'(1));
    chk("rst.full", 32'(full), 32'(0));
    chk("rst.aempty", 32'(almostempty), 32'(0));
    chk("rst.dout", 32'(data_out), 32'(0));
    chk("rst.ack", 32'(wr_ack), 32'(0));
    chk("rst.ovf", 32'(overflow), 32'(0));
    chk("rst.unf", 32'(underflow), 32'(0));
  endtask

  initial begin
    do_reset();

    // Mid-stream reset discards stored words.
    for (int i = 0; i < 3; i++) step(1, 0, 16'(16'h0A00 + i));
    do_reset();
    step(0, 1, '0);

    // Fill then overflow attempt.
    for (int i = 1; i <= D; i++) step(1, 0, 16'(i));
    step(1, 0, 16'hBEEF);
    for (int i = 0; i < D; i++) step(0, 1, '0);

    // Underflow on empty; data_out must hold.
    step(0, 1, '0);

    // Simultaneous requests while empty.
    step(1, 1, 16'h1234);
    step(0, 1, '0);

    // Simultaneous requests while full.
    for (int i = 0; i < D; i++) step(1, 0, 16'(16'h0100 + i));
    step(1, 1, 16'h5555);
    for (int i = 0; i < D-1; i++) step(0, 1, '0);

    // Wrap-around at constant occupancy of 4.
    for (int i = 0; i < 4; i++) step(1, 0, 16'(16'h2000 + i));
    for (int i = 4; i < 24; i++) begin
      step(1, 1, 16'(16'h2000 + i));
      chk("wrap.cnt", 32'(mq.size()), 32'(4));
    end
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    chk("sb.left", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
